// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the CPU memory stage and a word-wide synchronous RAM.
// Sub-word stores are read-modify-write. Loads return the selected lane, sign- or zero-extended.
module lsu_mem_ctrl #(
    parameter int XLEN = 32,
    parameter int DEPTH = 1024,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_data_i,
    input  logic [XLEN-1:0]   mem_data_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic              we_reg;
    logic [1:0]        size_reg;
    logic              uns_reg;
    logic [1:0]        lane_reg;
    logic [15:0]       wdata_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [XLEN-1:0]   mem_data_reg;
    logic [XLEN-1:0]   rdata_reg;
    logic              err_reg;

    logic              accept;
    logic              req_error;
    logic              word_store;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [XLEN-1:0]   load_ext;
    logic [XLEN-1:0]   merged;

    assign accept     = req_valid && (state_reg == IDLE);
    assign req_error  = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                     || (|req_addr[31:ADDR_W+2]);
    assign word_store = req_we && (req_size == 2'b10);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    if (req_error)       state_next = RESP;
                    else if (word_store) state_next = WRITE;
                    else                 state_next = RD;
                end
            end
            RD:      state_next = DATA;
            DATA:    state_next = we_reg ? WRITE : RESP;
            WRITE:   state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // Lane extraction and sign/zero extension of the word returned in DATA.
    assign byte_sel = mem_data_o[{lane_reg, 3'b000} +: 8];
    assign half_sel = mem_data_o[{lane_reg[1], 4'b0000} +: 16];

    always_comb begin
        load_ext = mem_data_o;
        case (size_reg)
            2'b00:   load_ext = {{(XLEN-8){~uns_reg & byte_sel[7]}}, byte_sel};
            2'b01:   load_ext = {{(XLEN-16){~uns_reg & half_sel[15]}}, half_sel};
            default: load_ext = mem_data_o;
        endcase
    end

    // Store merge: each byte lane takes store data only if the access covers it.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            localparam logic [1:0] LANE = 2'(gi);
            logic hit;
            assign hit = (size_reg == 2'b00) ? (lane_reg == LANE) : (lane_reg[1] == LANE[1]);
            assign merged[8*gi +: 8] = !hit ? mem_data_o[8*gi +: 8]
                                     : (size_reg == 2'b00) ? wdata_reg[7:0]
                                     : wdata_reg[8*LANE[0] +: 8];
        end
    endgenerate

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            we_reg       <= 1'b0;
            size_reg     <= 2'b00;
            uns_reg      <= 1'b0;
            lane_reg     <= 2'b00;
            wdata_reg    <= '0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            rdata_reg    <= '0;
            err_reg      <= 1'b0;
        end else begin
            if (accept) begin
                we_reg       <= req_we;
                size_reg     <= req_size;
                uns_reg      <= req_unsigned;
                lane_reg     <= req_addr[1:0];
                wdata_reg    <= req_wdata[15:0];
                mem_addr_reg <= req_addr[ADDR_W+1:2];
                err_reg      <= req_error;
                if (word_store && !req_error) mem_data_reg <= req_wdata;
            end
            if (state_reg == DATA) begin
                if (we_reg) mem_data_reg <= merged;
                else        rdata_reg    <= load_ext;
            end
            if (state_reg == RESP) begin
                rdata_reg <= '0;
                err_reg   <= 1'b0;
            end
        end
    end

    // Strobes decode straight from state so an async reset removes them at once.
    assign req_ready    = (state_reg == IDLE);
    assign resp_valid   = (state_reg == RESP);
    assign mem_write_en = (state_reg == WRITE);
    assign mem_addr     = mem_addr_reg;
    assign mem_data_i   = mem_data_reg;
    assign resp_rdata   = rdata_reg;
    assign resp_err     = err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl: the driver queues expected responses and RAM writes,
// and independent monitors compare them whenever the DUT responds or writes.
module tb_lsu_mem_ctrl;
    localparam int XLEN = 32;
    localparam int DEPTH = 1024;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_we = 1'b0;
    logic [1:0]        req_size = 2'b00;
    logic              req_unsigned = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [XLEN-1:0]   req_wdata = '0;
    logic              resp_valid;
    logic [XLEN-1:0]   resp_rdata;
    logic              resp_err;
    logic              mem_write_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [XLEN-1:0]   mem_data_i;
    logic [XLEN-1:0]   mem_data_o = '0;

    lsu_mem_ctrl #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
        .mem_data_i(mem_data_i), .mem_data_o(mem_data_o)
    );

    always #5 clock = ~clock;

    // Synchronous-read RAM model
    logic [XLEN-1:0] ram [0:DEPTH-1];
    always @(posedge clock) begin
        if (mem_write_en) ram[mem_addr] <= mem_data_i;
        mem_data_o <= ram[mem_addr];
    end

    int cycle = 0;
    always @(posedge clock) cycle <= cycle + 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
        int          id;
    } resp_t;
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        int                id;
    } wr_t;

    resp_t rq[$];
    wr_t   wq[$];
    int checks = 0;
    int failures = 0;
    int next_id = 0;
    logic prev_resp = 1'b0;

    always @(negedge clock) begin
        if (resp_valid) begin
            checks++;
            if (rq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_resp cycle=%0d rdata=%h err=%b", cycle, resp_rdata, resp_err);
            end else begin
                resp_t e;
                e = rq.pop_front();
                if (resp_rdata !== e.rdata) begin
                    failures++;
                    $display("FAIL resp%0d_rdata got=%h want=%h", e.id, resp_rdata, e.rdata);
                end
                checks++;
                if (resp_err !== e.err) begin
                    failures++;
                    $display("FAIL resp%0d_err got=%b want=%b", e.id, resp_err, e.err);
                end
                checks++;
                if (cycle != e.due) begin
                    failures++;
                    $display("FAIL resp%0d_latency got_cycle=%0d want_cycle=%0d", e.id, cycle, e.due);
                end
                $display("resp id=%0d rdata=%h err=%b cycle=%0d", e.id, resp_rdata, resp_err, cycle);
            end
        end else if (prev_resp) begin
            checks++;
            if (resp_rdata !== '0 || resp_err !== 1'b0) begin
                failures++;
                $display("FAIL clear_after_resp got rdata=%h err=%b want 0/0", resp_rdata, resp_err);
            end
        end
        prev_resp = resp_valid;
    end

    always @(negedge clock) begin
        if (mem_write_en) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_data_i);
            end else begin
                wr_t w;
                w = wq.pop_front();
                if (mem_addr !== w.addr || mem_data_i !== w.data) begin
                    failures++;
                    $display("FAIL write%0d got addr=%0d data=%h want addr=%0d data=%h",
                             w.id, mem_addr, mem_data_i, w.addr, w.data);
                end
            end
        end
    end

    task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err, input int lat,
                          input logic exp_wr, input logic [31:0] exp_wdata,
                          input logic hold, output int acc);
        int n;
        resp_t e;
        wr_t w;
        @(negedge clock);
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout id=%0d req_ready got=0 want=1", next_id);
            req_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cycle;
        e.rdata = exp_rdata; e.err = exp_err; e.due = acc + lat; e.id = next_id;
        rq.push_back(e);
        if (exp_wr) begin
            w.addr = addr[ADDR_W+1:2]; w.data = exp_wdata; w.id = next_id;
            wq.push_back(w);
        end
        $display("req id=%0d we=%b size=%b uns=%b addr=%h wdata=%h", next_id, we, size, uns, addr, wdata);
        next_id++;
        @(posedge clock);
        if (!hold) begin
            #1 req_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 40) begin
            @(negedge clock);
            n++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            checks++; failures++;
            $display("FAIL completion_timeout pending_resp=%0d pending_write=%0d want 0/0", rq.size(), wq.size());
            rq.delete();
            wq.delete();
        end
    endtask

    int a0, a1;

    initial begin
        repeat (2) @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_write_en !== 1'b0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got ready=%b rv=%b we=%b err=%b want 1/0/0/0", req_ready, resp_valid, mem_write_en, resp_err);
        end
        checks++;
        if (mem_addr !== '0 || mem_data_i !== '0 || resp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_data got addr=%h wdata=%h rdata=%h want 0", mem_addr, mem_data_i, resp_rdata);
        end
        reset_n = 1'b1;

        // we size uns addr wdata exp_rdata err lat wr exp_wdata hold
        do_req(1, 2'b10, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF, 0, a0); wait_done();
        do_req(0, 2'b10, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(1, 2'b00, 0, 32'h12,  32'hAAAAAA55, 32'h0,        0, 4, 1, 32'hDE55BEEF, 0, a0); wait_done();
        do_req(0, 2'b00, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b00, 1, 32'h13,  32'h0,        32'h000000DE, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b01, 0, 32'h10,  32'h0,        32'hFFFFBEEF, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b01, 1, 32'h12,  32'h0,        32'h0000DE55, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(1, 2'b01, 0, 32'h11,  32'h1234,     32'h0,        1, 1, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b10, 0, 32'h12,  32'h0,        32'h0,        1, 1, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b11, 0, 32'h10,  32'h0,        32'h0,        1, 1, 0, 32'h0,        0, a0); wait_done();
        do_req(1, 2'b10, 0, 32'h1000,32'h11111111, 32'h0,        1, 1, 0, 32'h0,        0, a0); wait_done();
        do_req(1, 2'b10, 0, 32'h0,   32'hA5A50001, 32'h0,        0, 2, 1, 32'hA5A50001, 0, a0); wait_done();
        do_req(1, 2'b01, 0, 32'h2,   32'h12347777, 32'h0,        0, 4, 1, 32'h77770001, 0, a0); wait_done();
        do_req(0, 2'b00, 0, 32'h3,   32'h0,        32'h00000077, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b10, 0, 32'h0,   32'h0,        32'h77770001, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(1, 2'b10, 0, 32'hFFC, 32'h80000000, 32'h0,        0, 2, 1, 32'h80000000, 0, a0); wait_done();
        do_req(0, 2'b00, 0, 32'hFFF, 32'h0,        32'hFFFFFF80, 0, 3, 0, 32'h0,        0, a0); wait_done();
        do_req(0, 2'b01, 1, 32'hFFE, 32'h0,        32'h00008000, 0, 3, 0, 32'h0,        0, a0); wait_done();

        // Back-to-back loads with req_valid held high throughout
        do_req(0, 2'b10, 0, 32'h10,  32'h0,        32'hDE55BEEF, 0, 3, 0, 32'h0,        1, a0);
        do_req(0, 2'b00, 1, 32'h12,  32'h0,        32'h00000055, 0, 3, 0, 32'h0,        0, a1);
        checks++;
        if (a1 - a0 != 4) begin
            failures++;
            $display("FAIL handshake_gap got=%0d want=4", a1 - a0);
        end
        wait_done();

        // Reset asserted in the WRITE cycle of a byte store to word 4
        @(negedge clock);
        req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h11; req_valid = 1'b1;
        $display("req id=rst we=1 size=00 addr=00000010 wdata=00000011");
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        checks++;
        if (mem_write_en !== 1'b1) begin
            failures++;
            $display("FAIL write_state_reached got mem_write_en=%b want=1", mem_write_en);
        end
        #1 reset_n = 1'b0;
        #1;
        checks++;
        if (mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_drops_write got mem_write_en=%b want=0", mem_write_en);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op got ready=%b rv=%b want 1/0", req_ready, resp_valid);
        end
        reset_n = 1'b1;
        do_req(0, 2'b10, 0, 32'h10,  32'h0,        32'hDE55BEEF, 0, 3, 0, 32'h0,        0, a0); wait_done();
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end
endmodule
